// File: rtl/audio_serial_tx.sv
// audio_serial_tx: stereo serial audio transmitter (LJ / I2S / RJ) with a
// show-ahead frame FIFO, internal BCK/LRCK generation, mute and underrun flag.
module audio_serial_tx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned BCK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [2*DATA_W-1:0]         wr_data,
    input  logic                        wr_req,
    output logic                        wr_full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    input  logic [1:0]                  fmt,
    input  logic                        mute,
    input  logic                        underrun_clr,
    output logic                        underrun,
    output logic                        bck,
    output logic                        lrck,
    output logic                        sdo
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned DIV_W = $clog2(BCK_DIV);
    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SW_B      = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] SW_M1_B   = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] DW_B      = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] DW_M1_B   = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] RJ_START  = BIT_W'(SLOT_W - DATA_W);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam bit               FULL_SLOT = (DATA_W == SLOT_W);
    localparam logic [1:0]       FMT_I2S   = 2'd1;
    localparam logic [1:0]       FMT_RJ    = 2'd2;

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   l_q;
    logic [DATA_W-1:0]   r_q;
    logic [1:0]          fmt_q;

    logic                fall_c;
    logic                load_c;
    logic                empty_c;
    logic                push_c;
    logic                pop_c;
    logic [DIV_W-1:0]    div_nxt_c;
    logic [BIT_W-1:0]    bit_nxt_c;
    logic [LVL_W-1:0]    level_nxt_c;
    logic [2*DATA_W-1:0] head_c;
    logic [DATA_W-1:0]   new_l_c;
    logic [DATA_W-1:0]   new_r_c;
    logic [DATA_W-1:0]   cur_l_c;
    logic [DATA_W-1:0]   cur_r_c;
    logic [DATA_W-1:0]   s_c;
    logic [1:0]          fmt_c;
    logic                right_c;
    logic [BIT_W-1:0]    p_c;
    logic                sdo_nxt_c;
    logic                lrck_nxt_c;

    // Timing strobes, FIFO bookkeeping and the sample feeding the frame load
    always_comb begin
        fall_c      = (div_cnt == DIV_LAST);
        div_nxt_c   = fall_c ? '0 : div_cnt + DIV_W'(1);
        bit_nxt_c   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        load_c      = fall_c && (bit_cnt == BIT_LAST);
        empty_c     = (level == '0);
        push_c      = wr_req && !wr_full;
        pop_c       = load_c && !empty_c;
        level_nxt_c = level + LVL_W'(push_c) - LVL_W'(pop_c);
        head_c      = mem[rd_ptr];
        new_l_c     = (empty_c || mute) ? '0 : head_c[2*DATA_W-1:DATA_W];
        new_r_c     = (empty_c || mute) ? '0 : head_c[DATA_W-1:0];
        cur_l_c     = load_c ? new_l_c : l_q;
        cur_r_c     = load_c ? new_r_c : r_q;
        fmt_c       = load_c ? fmt : fmt_q;
        right_c     = (bit_nxt_c >= SW_B);
        p_c         = right_c ? bit_nxt_c - SW_B : bit_nxt_c;
        s_c         = right_c ? cur_r_c : cur_l_c;
    end

    // Serial bit and word clock for the slot position about to start
    always_comb begin
        sdo_nxt_c  = 1'b0;
        lrck_nxt_c = !right_c;
        case (fmt_c)
            FMT_I2S: begin
                lrck_nxt_c = right_c;
                if (p_c == '0) begin
                    // Only a full-width slot has a trailing LSB spilling into p=0
                    if (FULL_SLOT) sdo_nxt_c = right_c ? cur_l_c[0] : r_q[0];
                end else if (p_c <= DW_B) begin
                    sdo_nxt_c = s_c[IDX_W'(DW_B - p_c)];
                end
            end
            FMT_RJ: begin
                if (p_c >= RJ_START) sdo_nxt_c = s_c[IDX_W'(SW_M1_B - p_c)];
                else                 sdo_nxt_c = s_c[DATA_W-1];
            end
            default: begin
                if (p_c < DW_B) sdo_nxt_c = s_c[IDX_W'(DW_M1_B - p_c)];
            end
        endcase
    end

    // Bit-clock divider and frame engine; serial outputs move only on fall events
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bck     <= 1'b0;
            bit_cnt <= BIT_LAST;
            l_q     <= '0;
            r_q     <= '0;
            fmt_q   <= '0;
            lrck    <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            div_cnt <= div_nxt_c;
            bck     <= (div_nxt_c >= DIV_HALF);
            if (fall_c) begin
                bit_cnt <= bit_nxt_c;
                lrck    <= lrck_nxt_c;
                sdo     <= sdo_nxt_c;
            end
            if (load_c) begin
                l_q   <= new_l_c;
                r_q   <= new_r_c;
                fmt_q <= fmt;
            end
        end
    end

    // FIFO pointers, occupancy, full flag and sticky underrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            wr_full  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            level   <= level_nxt_c;
            wr_full <= (level_nxt_c == LVL_FULL);
            if (load_c && empty_c) underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

    // Frame storage
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_audio_serial_tx.sv
// tb_audio_serial_tx: directed checks of reset, LJ/I2S/RJ framing, FIFO full,
// underrun, mute and asynchronous reset of audio_serial_tx.
module tb_audio_serial_tx;
    localparam int DATA_W     = 16;
    localparam int SLOT_W     = 32;
    localparam int BCK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int FR         = 2 * SLOT_W * BCK_DIV;

    logic                        clk = 1'b0;
    logic                        reset_n;
    logic [2*DATA_W-1:0]         wr_data;
    logic                        wr_req;
    logic                        wr_full;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic [1:0]                  fmt;
    logic                        mute;
    logic                        underrun_clr;
    logic                        underrun;
    logic                        bck;
    logic                        lrck;
    logic                        sdo;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [63:0] sv;
    logic [63:0] lv;

    audio_serial_tx #(
        .DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCK_DIV(BCK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_req(wr_req),
        .wr_full(wr_full), .level(level), .fmt(fmt), .mute(mute),
        .underrun_clr(underrun_clr), .underrun(underrun), .bck(bck),
        .lrck(lrck), .sdo(sdo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    // Advance to the next frame-load edge (edges 4 + k*FR after reset release)
    task automatic to_load();
        tick(1);
        while (((edge_n - 4) % FR) != 0) tick(1);
    endtask

    // Record one full frame of sdo/lrck starting at a load edge; optionally push one frame
    task automatic capture(input logic do_wr, input logic [31:0] d, input logic [1:0] nf,
                           output logic [63:0] s_v, output logic [63:0] l_v);
        fmt = nf;
        for (int k = 0; k < 64; k++) begin
            s_v[63-k] = sdo;
            l_v[63-k] = lrck;
            if (k == 0 && do_wr) begin
                wr_data = d;
                wr_req  = 1'b1;
                tick(1);
                wr_req  = 1'b0;
                tick(BCK_DIV - 1);
            end else begin
                tick(BCK_DIV);
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        wr_req       = 1'b0;
        wr_data      = '0;
        fmt          = 2'd0;
        mute         = 1'b0;
        underrun_clr = 1'b0;
        tick(3);
        chk("reset_outputs", 64'({bck, lrck, sdo, wr_full, level, underrun}), 64'd0);

        // Idle start: first fall event at edge 4, underrun set/clear/re-set
        reset_n = 1'b1;
        edge_n  = 0;
        tick(2);
        chk1("bck_edge2", bck, 1'b1);
        tick(1);
        chk1("underrun_edge3", underrun, 1'b0);
        tick(1);
        chk1("underrun_edge4", underrun, 1'b1);
        chk1("bck_edge4", bck, 1'b0);
        chk1("lrck_edge4", lrck, 1'b1);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        chk1("underrun_clr", underrun, 1'b0);
        tick(254);
        chk1("underrun_edge259", underrun, 1'b0);
        tick(1);
        chk1("underrun_edge260", underrun, 1'b1);

        // Fresh reset, then LJ, I2S and RJ frames back to back
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        edge_n  = 0;
        wr_data = {16'hA5F0, 16'h0F0F};
        wr_req  = 1'b1;
        tick(1);
        wr_req  = 1'b0;
        chk("level_after_write", 64'(level), 64'd1);
        tick(3);
        chk("level_after_pop", 64'(level), 64'd0);
        chk1("underrun_lj_load", underrun, 1'b0);
        capture(1'b1, {16'hA5F0, 16'h0F0F}, 2'd1, sv, lv);
        chk("lj_sdo", sv, {16'hA5F0, 16'h0000, 16'h0F0F, 16'h0000});
        chk("lj_lrck", lv, {32'hFFFF_FFFF, 32'h0});
        capture(1'b1, {16'h8001, 16'h0001}, 2'd2, sv, lv);
        chk("i2s_sdo", sv, {1'b0, 16'hA5F0, 15'h0, 1'b0, 16'h0F0F, 15'h0});
        chk("i2s_lrck", lv, {32'h0, 32'hFFFF_FFFF});
        capture(1'b0, 32'h0, 2'd0, sv, lv);
        chk("rj_sdo", sv, {16'hFFFF, 16'h8001, 16'h0000, 16'h0001});
        chk("rj_lrck", lv, {32'hFFFF_FFFF, 32'h0});
        chk1("underrun_after_rj", underrun, 1'b1);

        // FIFO full: nine writes mid-frame, ninth dropped, then drain in order
        tick(10);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        chk1("underrun_clr2", underrun, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            wr_data = {16'(i), 16'(16'h10 + i)};
            wr_req  = 1'b1;
            tick(1);
            if (i == 8) begin
                chk("level_full", 64'(level), 64'd8);
                chk1("wr_full_set", wr_full, 1'b1);
            end
        end
        wr_req = 1'b0;
        chk("level_after_drop", 64'(level), 64'd8);
        chk1("wr_full_hold", wr_full, 1'b1);
        to_load();
        chk1("wr_full_clear", wr_full, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            chk("level_drain", 64'(level), 64'(8 - i));
            chk1("underrun_drain", underrun, 1'b0);
            capture(1'b0, 32'h0, 2'd0, sv, lv);
            chk("fifo_frame_sdo", sv, {16'(i), 16'h0000, 16'(16'h10 + i), 16'h0000});
        end
        chk1("underrun_after_drain", underrun, 1'b1);
        capture(1'b0, 32'h0, 2'd0, sv, lv);
        chk("empty_frame_sdo", sv, 64'd0);

        // Mute: queued frames drain with silent output
        mute = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = {16'hFFFF, 16'hFFFF};
            wr_req  = 1'b1;
            tick(1);
        end
        wr_req = 1'b0;
        to_load();
        chk("mute_level0", 64'(level), 64'd2);
        capture(1'b0, 32'h0, 2'd0, sv, lv);
        chk("mute_sdo0", sv, 64'd0);
        chk("mute_lrck0", lv, {32'hFFFF_FFFF, 32'h0});
        chk("mute_level1", 64'(level), 64'd1);
        capture(1'b0, 32'h0, 2'd2, sv, lv);
        chk("mute_sdo1", sv, 64'd0);
        chk("mute_level2", 64'(level), 64'd0);
        mute = 1'b0;

        // Reset mid-frame at bit 20 of an RJ frame with one frame still queued
        for (int i = 0; i < 2; i++) begin
            wr_data = {16'hFFFF, 16'hFFFF};
            wr_req  = 1'b1;
            tick(1);
        end
        wr_req = 1'b0;
        to_load();
        tick(20 * BCK_DIV + 2);
        chk("pre_reset_pins", 64'({bck, lrck, sdo}), 64'b111);
        chk("pre_reset_level", 64'(level), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({bck, lrck, sdo, wr_full, level, underrun}), 64'd0);
        tick(1);
        reset_n = 1'b1;
        edge_n  = 0;
        fmt     = 2'd0;
        tick(4);
        chk("post_reset_level", 64'(level), 64'd0);
        chk1("post_reset_underrun", underrun, 1'b1);
        chk1("post_reset_sdo", sdo, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
